// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path.
//   NREG     number of architectural registers in the bank
//   RADDR_W  register index width
//   onehot8  index -> one-hot bank write enable
package rf_pkg;

    localparam int NREG    = 8;
    localparam int RADDR_W = 3;

    function automatic logic [NREG-1:0] onehot8(input logic [RADDR_W-1:0] addr);
        logic [NREG-1:0] r;
        r       = '0;
        r[addr] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rf_wfifo.sv
// In-order write-request FIFO.
//   push/pop   enqueue din / dequeue head (caller guarantees no push when full,
//              no pop when empty)
//   dout       head entry
//   full/empty occupancy flags; count = entries held (0..DEPTH)
//   vld        per-slot occupied bits
//   tags       top TW bits of every slot, so the consumer can scan all
//              queued entries without reading the whole payload
module rf_wfifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 35,
    parameter int TW    = 3,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic                       full,
    output logic                       empty,
    output logic [CW-1:0]              count,
    output logic [DEPTH-1:0]           vld,
    output logic [DEPTH-1:0][TW-1:0]   tags
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DEPTH-1:0]         vld_q, vld_d;

    // Payload storage needs no reset: vld_q qualifies every slot.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        if (pop) begin
            rptr_d        = rptr_q + 1'b1;
            vld_d[rptr_q] = 1'b0;
        end
        if (push) begin
            wptr_d        = wptr_q + 1'b1;
            vld_d[wptr_q] = 1'b1;
        end
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) tags[i] = mem_q[i][DW-1 -: TW];
    end

    assign dout  = mem_q[rptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign vld   = vld_q;

endmodule

// File: rtl/rf_write_ctrl.sv
// Write-port controller in front of the 8x32 register bank.
//   wr_valid/wr_ready/wr_addr/wr_data  request handshake from the result path
//   hold     1 = issue nothing this cycle (requests still buffered)
//   en       registered one-hot bank write enable
//   d_out    registered bank write data (holds when nothing issues)
//   pending  registers targeted by a queued or currently issuing write
//   count    FIFO occupancy
module rf_write_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [RADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    hold,
    output logic [NREG-1:0]         en,
    output logic [WIDTH-1:0]        d_out,
    output logic [NREG-1:0]         pending,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int DW = WIDTH + RADDR_W;

    logic                             accept, bypass, f_push, f_pop;
    logic                             f_full, f_empty;
    logic [DW-1:0]                    f_dout;
    logic [DEPTH-1:0]                 f_vld;
    logic [DEPTH-1:0][RADDR_W-1:0]    f_tags;
    logic [NREG-1:0]                  en_q, en_d;
    logic [WIDTH-1:0]                 d_q, d_d;

    // Ready depends only on occupancy, never on hold or wr_valid.
    assign wr_ready = !f_full;
    assign accept   = wr_valid && wr_ready;
    // An empty FIFO with an open issue slot forwards the request directly;
    // ordering is safe since nothing older is waiting.
    assign bypass   = accept && f_empty && !hold;
    assign f_push   = accept && !bypass;
    assign f_pop    = !hold && !f_empty;

    rf_wfifo #(.DEPTH(DEPTH), .DW(DW), .TW(RADDR_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (f_push),
        .pop   (f_pop),
        .din   ({wr_addr, wr_data}),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (count),
        .vld   (f_vld),
        .tags  (f_tags)
    );

    always_comb begin
        en_d = '0;
        d_d  = d_q;
        if (f_pop) begin
            en_d = onehot8(f_dout[DW-1 -: RADDR_W]);
            d_d  = f_dout[WIDTH-1:0];
        end else if (bypass) begin
            en_d = onehot8(wr_addr);
            d_d  = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= '0;
            d_q  <= '0;
        end else begin
            en_q <= en_d;
            d_q  <= d_d;
        end
    end

    // The issuing write still counts as pending until the bank captures it.
    always_comb begin
        pending = en_q;
        for (int i = 0; i < DEPTH; i++)
            if (f_vld[i]) pending = pending | onehot8(f_tags[i]);
    end

    assign en    = en_q;
    assign d_out = d_q;

endmodule
